// File: rtl/button_debouncer_multi.sv
// N-channel pad conditioner: 2-FF sync, stability-count debounce,
// level/press/release outputs and optional hold auto-repeat.
module button_debouncer_multi #(
  parameter int CHANNELS      = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_DELAY    = 1000,
  parameter int REPEAT_PERIOD = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] rep_pulse
);

  localparam int CW   = $clog2(STABLE_CYCLES) + 1;
  localparam int HMAX = (HOLD_DELAY > REPEAT_PERIOD) ?
                        HOLD_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic [CW-1:0] CNT_END  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_DELAY - 1);
  localparam logic [HW-1:0] PER_END  = HW'(REPEAT_PERIOD - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  typedef enum logic {
    PH_FIRST,
    PH_REP
  } phase_e;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic          s0_q, s1_q;
      logic          lvl_q, lvl_d;
      logic          prs_q, prs_d;
      logic          rel_q, rel_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Any sample agreeing with the level restarts the count.
      always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        prs_d = 1'b0;
        rel_d = 1'b0;
        if (s1_q != lvl_q) begin
          if (cnt_q == CNT_END) begin
            lvl_d = s1_q;
            prs_d = s1_q;
            rel_d = ~s1_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s0_q  <= 1'b0;
          s1_q  <= 1'b0;
          cnt_q <= '0;
          lvl_q <= 1'b0;
          prs_q <= 1'b0;
          rel_q <= 1'b0;
        end else begin
          s0_q  <= btn_in[i] ^ INV;
          s1_q  <= s0_q;
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
          prs_q <= prs_d;
          rel_q <= rel_d;
        end
      end

      assign btn_level[i]     = lvl_q;
      assign press_pulse[i]   = prs_q;
      assign release_pulse[i] = rel_q;

      if (REPEAT_EN != 0) begin : g_rep
        phase_e        ph_q, ph_d;
        logic [HW-1:0] hc_q, hc_d;
        logic          rep_q, rep_d;

        // A release accepted this edge wins over a due repeat.
        always_comb begin
          ph_d  = PH_FIRST;
          hc_d  = '0;
          rep_d = 1'b0;
          if (lvl_q && !rel_d) begin
            unique case (ph_q)
              PH_FIRST: begin
                if (hc_q == HOLD_END) begin
                  rep_d = 1'b1;
                  ph_d  = PH_REP;
                end else begin
                  hc_d  = hc_q + 1'b1;
                end
              end
              PH_REP: begin
                ph_d = PH_REP;
                if (hc_q == PER_END) begin
                  rep_d = 1'b1;
                end else begin
                  hc_d  = hc_q + 1'b1;
                end
              end
            endcase
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            ph_q  <= PH_FIRST;
            hc_q  <= '0;
            rep_q <= 1'b0;
          end else begin
            ph_q  <= ph_d;
            hc_q  <= hc_d;
            rep_q <= rep_d;
          end
        end

        assign rep_pulse[i] = rep_q;
      end else begin : g_norep
        assign rep_pulse[i] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: directed tables, hand sequences
// and random stimulus against a sample-history reference model.
module tb_button_debouncer_multi;

  localparam int CH = 4;
  localparam int S  = 4;
  localparam int H  = 10;
  localparam int P  = 4;
  localparam int NE = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] rep_pulse;

  button_debouncer_multi #(
    .CHANNELS     (CH),
    .ACTIVE_LOW   (1),
    .STABLE_CYCLES(S),
    .REPEAT_EN    (1),
    .HOLD_DELAY   (H),
    .REPEAT_PERIOD(P)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .rep_pulse    (rep_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pressed-sense sample seen at each edge, per channel.
  bit xh [CH][NE];
  int n = 0;
  bit lvl_m  [CH];
  int last_m [CH];
  int pedge_m[CH];
  logic [CH-1:0] e_lvl, e_prs, e_rel, e_rep;

  task automatic chk(string name, logic [CH-1:0] act,
                     logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d got %b want %b", name, n, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at edge %0d", name, n);
  endtask

  function automatic bit samp(int c, int m);
    if (m - 2 < 0) return 1'b0;
    return xh[c][m-2];
  endfunction

  // Level flips once S consecutive synced samples, all taken since
  // the last change, disagree with it.
  task automatic model(bit rst);
    bit flip;
    int t;
    for (int c = 0; c < CH; c++) begin
      e_prs[c] = 1'b0;
      e_rel[c] = 1'b0;
      e_rep[c] = 1'b0;
      if (rst) begin
        xh[c][n] = 1'b0;
        if (n > 0) xh[c][n-1] = 1'b0;
        lvl_m[c]  = 1'b0;
        last_m[c] = n;
      end else begin
        flip = (n - S >= last_m[c]);
        for (int k = 0; k < S; k++)
          if (samp(c, n - k) == lvl_m[c]) flip = 1'b0;
        t = n - pedge_m[c];
        if (!flip && lvl_m[c] && t >= H && ((t - H) % P) == 0)
          e_rep[c] = 1'b1;
        if (flip) begin
          lvl_m[c]  = ~lvl_m[c];
          last_m[c] = n;
          e_prs[c]  = lvl_m[c];
          e_rel[c]  = ~lvl_m[c];
          if (lvl_m[c]) pedge_m[c] = n;
        end
      end
      e_lvl[c] = lvl_m[c];
    end
  endtask

  task automatic step();
    bit r;
    for (int c = 0; c < CH; c++) xh[c][n] = ~btn_in[c];
    r = reset;
    @(posedge clk);
    #1;
    model(r);
    chk("level", btn_level, e_lvl);
    chk("press", press_pulse, e_prs);
    chk("release", release_pulse, e_rel);
    chk("repeat", rep_pulse, e_rep);
    chk("excl", press_pulse & release_pulse, '0);
    if (n < NE - 1) n++;
  endtask

  task automatic wait_press(int c, string name);
    int k;
    k = 0;
    while (!press_pulse[c] && k < 20) begin
      step();
      k++;
    end
    if (!press_pulse[c]) timeout_fail(name);
  endtask

  typedef struct {
    logic [CH-1:0] btn;
    int            cyc;
    logic [CH-1:0] lvl;
  } vec_t;

  vec_t tbl [8];
  logic [CH-1:0] pulses;
  int hold [CH];

  initial begin
    tbl[0] = '{4'b1010, 3, 4'b0100};
    tbl[1] = '{4'b1011, 2, 4'b0100};
    tbl[2] = '{4'b1010, 3, 4'b0100};
    tbl[3] = '{4'b1010, 6, 4'b0101};
    tbl[4] = '{4'b1000, 8, 4'b0111};
    tbl[5] = '{4'b1010, 10, 4'b0101};
    tbl[6] = '{4'b1000, 3, 4'b0101};
    tbl[7] = '{4'b1111, 9, 4'b0000};

    for (int c = 0; c < CH; c++) begin
      lvl_m[c] = 0;
      last_m[c] = 0;
      pedge_m[c] = 0;
    end

    // Reset with all pads released (inputs high).
    reset  = 1'b1;
    btn_in = 4'hF;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("rst_level", btn_level, '0);
    end
    reset  = 1'b0;
    pulses = '0;
    for (int j = 0; j < 20; j++) begin
      step();
      pulses |= press_pulse | release_pulse | rep_pulse;
    end
    chk("post_rst_pulses", pulses, '0);

    // Clean press on ch2: level rises 5 edges after edge k.
    btn_in = 4'b1011;
    for (int j = 1; j <= 7; j++) begin
      step();
      chk("p2_level", btn_level, (j >= 6) ? 4'b0100 : 4'b0000);
      chk("p2_press", press_pulse, (j == 6) ? 4'b0100 : 4'b0000);
    end

    // Glitches on ch0, then press/release on ch1.
    for (int v = 0; v < 8; v++) begin
      btn_in = tbl[v].btn;
      for (int j = 0; j < tbl[v].cyc; j++) step();
      chk("tbl_level", btn_level, tbl[v].lvl);
    end
    for (int j = 0; j < 30; j++) step();

    // Auto-repeat on ch1, release lands on a due repeat edge.
    btn_in = 4'b1101;
    wait_press(1, "rep_press_wait");
    for (int j = 1; j <= 60; j++) begin
      if (j == 41) btn_in = 4'b1111;
      step();
      chk("rep_seq", {3'b0, rep_pulse[1]},
          {3'b0, (j < 46 && j >= H && ((j - H) % P) == 0)});
      chk("rel_seq", {3'b0, release_pulse[1]}, {3'b0, j == 46});
    end
    btn_in = 4'b1101;
    wait_press(1, "repress_wait");
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("rep_again", {3'b0, rep_pulse[1]}, {3'b0, j == H});
    end
    btn_in = 4'b1111;
    for (int j = 0; j < 10; j++) step();

    // Simultaneous press on ch0 and ch3.
    btn_in = 4'b0110;
    wait_press(0, "dual_press_wait");
    chk("dual_press", press_pulse, 4'b1001);
    btn_in = 4'b1111;
    for (int j = 0; j < 10; j++) step();

    // Reset mid-count on ch1 discards progress.
    btn_in = 4'b1101;
    for (int j = 0; j < 3; j++) step();
    reset = 1'b1;
    step();
    chk("midrst_level", btn_level, '0);
    reset = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("midrst_press", press_pulse, (j == 6) ? 4'b0010 : 4'b0000);
    end
    btn_in = 4'b1111;
    for (int j = 0; j < 10; j++) step();

    // Random bursts with occasional resets.
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int j = 0; j < 2000; j++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_in[c] = ~btn_in[c];
          hold[c] = $urandom_range(1, 12);
          if ($urandom_range(0, 3) == 0) hold[c] = $urandom_range(20, 40);
        end
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
